// File: rtl/stat_pkg.sv
// Shared constants and helpers for the statistics counter bank: address field
// layout, index widths and the counter increment rule.
package stat_pkg;

    localparam int LOHI_BIT = 2;
    localparam int EVT_LSB  = 3;
    localparam logic [31:0] RD_MISS = 32'h0;

    function automatic int clog2(input int n);
        int r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Address fields and select ports are never narrower than one bit.
    function automatic int field_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic logic [63:0] cnt_inc(input logic [63:0] v, input int w, input bit sat);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        if (v == max_v) return sat ? max_v : 64'd0;
        return v + 64'd1;
    endfunction

endpackage

// File: rtl/stat_counter_bank_if.sv
// CPU read port of the statistics counter bank.
// up_rd is a one-cycle strobe with no back-pressure; up_data_rd is valid the
// cycle after the strobe and holds until the next strobe.
interface stat_counter_bank_if;
    logic        up_rd;
    logic [31:0] up_addr;
    logic [31:0] up_data_rd;

    modport master (output up_rd, output up_addr, input up_data_rd);
    modport slave  (input up_rd, input up_addr, output up_data_rd);
endinterface

// File: rtl/stat_cnt_cell.sv
// One event counter: global clear, clear-on-read merged with a same-edge
// increment, and saturating or wrapping increment.
module stat_cnt_cell
    import stat_pkg::*;
#(
    parameter int CNT_W    = 48,
    parameter int SAT_MODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             rd_clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         cnt <= '0;
        else if (clr)    cnt <= '0;
        else if (rd_clr) cnt <= CNT_W'(inc);
        else if (inc)    cnt <= CNT_W'(cnt_inc(64'(cnt), CNT_W, SAT_MODE != 0));
    end

endmodule

// File: rtl/stat_counter_bank.sv
// Multi-channel event counter bank with coherent lo/hi CPU reads.
// Optional macro STAT_SNAPSHOT_EN adds snap_in and a shadow bank that CPU reads target.
module stat_counter_bank
    import stat_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          NUM_EVT   = 16,
    parameter int          CNT_W     = 48,
    parameter int          SAT_MODE  = 1,
    parameter int          CLR_ON_RD = 0,
    parameter logic [15:0] BASE_ADDR = 16'h0800
) (
    input  logic                         clk,
    input  logic                         rst,
    stat_counter_bank_if.slave           up,
    input  logic                         clr_in,
    input  logic                         stat_chk,
    input  logic [field_w(NUM_CH)-1:0]   stat_ch,
    input  logic [NUM_EVT-1:0]           stat_bit
`ifdef STAT_SNAPSHOT_EN
    ,
    input  logic                         snap_in
`endif
);

    localparam int CH_AW    = field_w(NUM_CH);
    localparam int EVT_AW   = field_w(NUM_EVT);
    localparam int N_CNT    = NUM_CH * NUM_EVT;
    localparam int IDX_W    = field_w(N_CNT);
    localparam int CH_LSB   = EVT_LSB + EVT_AW;
    localparam int ADDR_TOP = CH_LSB + CH_AW;

    logic               stg_vld;
    logic [CH_AW-1:0]   stg_ch;
    logic [NUM_EVT-1:0] stg_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_vld <= 1'b0;
            stg_ch  <= '0;
            stg_bit <= '0;
        end else begin
            stg_vld <= stat_chk && !clr_in;
            if (stat_chk && !clr_in) begin
                stg_ch  <= stat_ch;
                stg_bit <= stat_bit;
            end
        end
    end

    logic [CH_AW-1:0]  ch_idx;
    logic [EVT_AW-1:0] evt_idx;
    logic [IDX_W-1:0]  sel_idx;
    logic              hi_sel, in_range, rd_hit, lo_hit;
    logic              unused_addr_bits;

    assign ch_idx   = up.up_addr[CH_LSB +: CH_AW];
    assign evt_idx  = up.up_addr[EVT_LSB +: EVT_AW];
    assign hi_sel   = up.up_addr[LOHI_BIT];
    assign in_range = (int'(ch_idx) < NUM_CH) && (int'(evt_idx) < NUM_EVT);
    assign rd_hit   = up.up_rd && (up.up_addr[31:16] == BASE_ADDR) && in_range;
    assign lo_hit   = rd_hit && !hi_sel;
    assign sel_idx  = IDX_W'(int'(ch_idx) * NUM_EVT + int'(evt_idx));
    assign unused_addr_bits = ^{up.up_addr[1:0], up.up_addr[15:ADDR_TOP]};

    logic [CNT_W-1:0] cnt [N_CNT];
    logic [N_CNT-1:0] rd_clr;
    logic [63:0]      rd_val;

`ifdef STAT_SNAPSHOT_EN
    logic [CNT_W-1:0] shadow [N_CNT];

    // A snapshot is the only clear-on-read event; CPU reads of the shadow are side-effect free.
    assign rd_clr = {N_CNT{(CLR_ON_RD != 0) && snap_in}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CNT; i++) shadow[i] <= '0;
        end else if (clr_in) begin
            for (int i = 0; i < N_CNT; i++) shadow[i] <= '0;
        end else if (snap_in) begin
            for (int i = 0; i < N_CNT; i++) shadow[i] <= cnt[i];
        end
    end

    assign rd_val = 64'(shadow[sel_idx]);
`else
    always_comb begin
        rd_clr = '0;
        if ((CLR_ON_RD != 0) && lo_hit) rd_clr[sel_idx] = 1'b1;
    end

    assign rd_val = 64'(cnt[sel_idx]);
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        for (genvar e = 0; e < NUM_EVT; e++) begin : g_evt
            logic inc;
            assign inc = stg_vld && (int'(stg_ch) == c) && stg_bit[e];

            stat_cnt_cell #(
                .CNT_W    (CNT_W),
                .SAT_MODE (SAT_MODE)
            ) u_cell (
                .clk    (clk),
                .rst    (rst),
                .clr    (clr_in),
                .inc    (inc),
                .rd_clr (rd_clr[c*NUM_EVT+e]),
                .cnt    (cnt[c*NUM_EVT+e])
            );
        end
    end

    logic [31:0]      rd_data;
    logic [31:0]      hi_val;
    logic [IDX_W-1:0] hi_idx;
    logic             hi_vld;

    // The hi latch keeps a 64-bit value coherent across the lo-then-hi read pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
            hi_val  <= '0;
            hi_idx  <= '0;
            hi_vld  <= 1'b0;
        end else begin
            if (up.up_rd) begin
                if (!rd_hit)                              rd_data <= RD_MISS;
                else if (!hi_sel)                         rd_data <= rd_val[31:0];
                else if (hi_vld && (hi_idx == sel_idx))   rd_data <= hi_val;
                else                                      rd_data <= rd_val[63:32];
            end
            if (clr_in) begin
                hi_val <= '0;
                hi_vld <= 1'b0;
            end else if (lo_hit) begin
                hi_val <= rd_val[63:32];
                hi_idx <= sel_idx;
                hi_vld <= 1'b1;
            end
        end
    end

    assign up.up_data_rd = rd_data;

endmodule
